uart_tx_arbiter: RTL and testbench

Shares the single SOC UART transmitter between two byte producers: requester 0 (CPU memory-mapped TX register) and requester 1 (hardware echo of received calculator keystrokes).
- Each requester owns a one-byte holding register.
- A round-robin scheduler issues held bytes to the TX core through a start/busy handshake.
- An optional inter-byte gap is inserted after each byte.

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART TX core between two single-byte producers. Each producer
// owns a one-byte holding register; a round-robin scheduler issues held bytes
// to the TX core over a start/busy handshake, with an optional idle gap after
// each frame and a guard against a TX core that never raises busy.
module uart_tx_arbiter #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 0,
    parameter int BUSY_TO    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              grant_id,
    output logic              active
);

    // One counter serves both the busy timeout and the gap, so it is sized
    // for whichever of the two needs more range.
    localparam int CNT_MAX = (BUSY_TO > GAP_CYCLES) ? BUSY_TO : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              full0;
    logic              full1;
    logic [DATA_W-1:0] held0;
    logic [DATA_W-1:0] held1;
    logic              last_grant;

    logic              sel;
    logic              winner;

    // A requester may hand over a new byte whenever its holding register is empty.
    assign req0_ready = ~full0;
    assign req1_ready = ~full1;

    // tx_start is a decode of the registered state, so it is glitch-free and
    // lasts exactly the single ISSUE cycle.
    assign tx_start = (state == ISSUE);
    assign active   = (state != IDLE);

    // Winner selection: the only full register, or on a tie the one not served last.
    assign winner = (full0 && full1) ? ~last_grant : full1;

    // State register and shared timeout/gap counter.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would make results depend on
        // statement order and diverge between simulation and synthesis.
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: select, issue, wait for busy (with timeout), wait for
    // frame end, optional gap.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_next = state;
        cnt_next   = cnt;
        sel        = 1'b0;
        case (state)
            IDLE: begin
                if (full0 || full1) begin
                    sel        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end
            WAIT_BUSY: begin
                // A TX core that never answers must not stall both producers;
                // after the timeout the byte is treated as sent.
                if (tx_busy || (cnt == BUSY_LAST)) begin
                    state_next = WAIT_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        cnt_next   = GAP_LAST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding registers, issued byte and round-robin history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the byte registers are reset as well: a reset must drop held
            // bytes and drive tx_data to zero, and there are only a few of them.
            full0      <= 1'b0;
            full1      <= 1'b0;
            held0      <= '0;
            held1      <= '0;
            tx_data    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            // Capture and issue never target the same register in one cycle:
            // capture needs it empty, issue needs it full.
            if (req0_valid && !full0) begin
                held0 <= req0_data;
                full0 <= 1'b1;
            end
            if (req1_valid && !full1) begin
                held1 <= req1_data;
                full1 <= 1'b1;
            end
            if (sel) begin
                tx_data    <= winner ? held1 : held0;
                grant_id   <= winner;
                last_grant <= winner;
                if (winner) begin
                    full1 <= 1'b0;
                end else begin
                    full0 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Scoreboarded bench: expected (grant, byte) pairs are queued as stimulus is
// driven and popped whenever the arbiter pulses tx_start. A small TX core model
// answers each start with busy for 20 clocks, starting one clock later.
// A second instance with GAP_CYCLES=5 covers the inter-byte gap.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 20;

    logic       clk;
    logic       resetn;

    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       grant_id;
    logic       active;

    logic       g_req0_valid;
    logic [7:0] g_req0_data;
    logic       g_req0_ready;
    logic       g_req1_valid;
    logic [7:0] g_req1_data;
    logic       g_req1_ready;
    logic       g_tx_start;
    logic [7:0] g_tx_data;
    logic       g_tx_busy;
    logic       g_grant_id;
    logic       g_active;

    uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(0), .BUSY_TO(16)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active)
    );

    uart_tx_arbiter #(.DATA_W(8), .GAP_CYCLES(5), .BUSY_TO(16)) u_dut_gap (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (g_req0_valid),
        .req0_data  (g_req0_data),
        .req0_ready (g_req0_ready),
        .req1_valid (g_req1_valid),
        .req1_data  (g_req1_data),
        .req1_ready (g_req1_ready),
        .tx_start   (g_tx_start),
        .tx_data    (g_tx_data),
        .tx_busy    (g_tx_busy),
        .grant_id   (g_grant_id),
        .active     (g_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       gid;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   start_times[$];
    int   n_checks   = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   start_cnt  = 0;
    int   busy_left  = 0;
    logic arm        = 1'b0;
    logic tx_respond = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and TX core model, both on the falling edge, away from the DUT's edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tx_start) begin
            start_cnt++;
            start_times.push_back(cyc);
            check("start_while_busy", {31'b0, (tx_busy | arm | (busy_left > 0))}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                check("tx_data", {24'b0, tx_data}, {24'b0, e.data});
                check("grant_id", {31'b0, grant_id}, {31'b0, e.gid});
            end
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end else if (arm) begin
            arm       = 1'b0;
            tx_busy   = 1'b1;
            busy_left = BUSY_LEN;
        end
        if (tx_start && tx_respond) arm = 1'b1;
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req0_ready"}, {31'b0, req0_ready}, 32'd1);
        check({pfx, "_req1_ready"}, {31'b0, req1_ready}, 32'd1);
        check({pfx, "_tx_start"},   {31'b0, tx_start},   32'd0);
        check({pfx, "_tx_data"},    {24'b0, tx_data},    32'd0);
        check({pfx, "_grant_id"},   {31'b0, grant_id},   32'd0);
        check({pfx, "_active"},     {31'b0, active},     32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Waits until nothing is in flight and every expected byte has been issued.
    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((active || sb.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, (n < 1000)}, 32'd1);
    endtask

    // Holds valid until the byte is captured; returns on the falling edge after capture.
    task automatic send0(input logic [7:0] d);
        int n = 0;
        req0_valid = 1'b1;
        req0_data  = d;
        while (!req0_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("send0_accept", {31'b0, (n < 1000)}, 32'd1);
    endtask

    task automatic send1(input logic [7:0] d);
        int n = 0;
        req1_valid = 1'b1;
        req1_data  = d;
        while (!req1_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("send1_accept", {31'b0, (n < 1000)}, 32'd1);
    endtask

    initial begin
        int s0;
        int n;
        resetn       = 1'b0;
        req0_valid   = 1'b0;
        req0_data    = '0;
        req1_valid   = 1'b0;
        req1_data    = '0;
        tx_busy      = 1'b0;
        g_req0_valid = 1'b0;
        g_req0_data  = '0;
        g_req1_valid = 1'b0;
        g_req1_data  = '0;
        g_tx_busy    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Single byte: capture, select one edge later, ready low for one cycle.
        s0         = start_cnt;
        req0_valid = 1'b1;
        req0_data  = 8'h34;
        sb.push_back('{gid: 1'b0, data: 8'h34});
        @(negedge clk);
        check("t1_ready_low", {31'b0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_ready_high", {31'b0, req0_ready}, 32'd1);
        check("t1_start_latency", {31'b0, tx_start}, 32'd1);
        wait_idle("t1_idle");
        check("t1_start_count", start_cnt - s0, 32'd1);

        // Tie after reset: requester 0 wins first.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h2A;
        req1_valid = 1'b1;
        req1_data  = 8'h35;
        sb.push_back('{gid: 1'b0, data: 8'h2A});
        sb.push_back('{gid: 1'b1, data: 8'h35});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("t2_idle");

        // Sustained round-robin with both producers streaming.
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{gid: 1'b0, data: 8'(8'h30 + i)});
            sb.push_back('{gid: 1'b1, data: 8'(8'h39 + i)});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) send0(8'(8'h30 + i));
                req0_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) send1(8'(8'h39 + j));
                req1_valid = 1'b0;
            end
        join
        wait_idle("t3_idle");

        // Busy timeout: 16 WAIT_BUSY clocks, then WAIT_DONE, IDLE select and
        // ISSUE, so successive starts are 19 clocks apart.
        tx_respond = 1'b0;
        start_times.delete();
        req0_valid = 1'b1;
        req0_data  = 8'h50;
        req1_valid = 1'b1;
        req1_data  = 8'h51;
        sb.push_back('{gid: 1'b0, data: 8'h50});
        sb.push_back('{gid: 1'b1, data: 8'h51});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("t4_idle");
        check("t4_start_count", start_times.size(), 32'd2);
        if (start_times.size() == 2) begin
            check("t4_interval", start_times[1] - start_times[0], 32'd19);
        end
        tx_respond = 1'b1;

        // Gap of 5 on the second instance. Busy drops mid-cycle; the next edge
        // enters GAP, five GAP clocks follow, the select edge comes next and
        // tx_start is seen at the falling edge after it: 7 falling edges later.
        do_reset();
        g_req0_valid = 1'b1;
        g_req0_data  = 8'h41;
        g_req1_valid = 1'b1;
        g_req1_data  = 8'h42;
        @(negedge clk);
        g_req0_valid = 1'b0;
        g_req1_valid = 1'b0;
        n = 0;
        while (!g_tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_start", {31'b0, g_tx_start}, 32'd1);
        check("t5_first_data", {24'b0, g_tx_data}, 32'h41);
        check("t5_first_grant", {31'b0, g_grant_id}, 32'd0);
        @(negedge clk);
        g_tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        g_tx_busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_tx_start && n < 50);
        check("t5_gap_interval", n, 32'd7);
        check("t5_second_data", {24'b0, g_tx_data}, 32'h42);
        check("t5_second_grant", {31'b0, g_grant_id}, 32'd1);

        // Reset during WAIT_DONE with requester 1 still holding a byte.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h60;
        req1_valid = 1'b1;
        req1_data  = 8'h61;
        sb.push_back('{gid: 1'b0, data: 8'h60});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("t6_pre_active", {31'b0, active}, 32'd1);
        check("t6_pre_req1_ready", {31'b0, req1_ready}, 32'd0);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("t6_async");
        @(negedge clk);
        resetn = 1'b1;
        s0 = start_cnt;
        repeat (40) @(negedge clk);
        check("t6_no_start", start_cnt - s0, 32'd0);
        sb.push_back('{gid: 1'b1, data: 8'h62});
        send1(8'h62);
        req1_valid = 1'b0;
        wait_idle("t6_idle");
        check("t6_new_start", start_cnt - s0, 32'd1);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
